// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tube_pkg
// Description : Shared types and helpers for the tube writeback buffer.
// Revision    : 1.0  initial release
// ============================================================================
package tube_pkg;

    // Storage fields are sized for the widest supported configuration.
    // Each instance zero-extends on write and truncates on read.
    localparam int TUBE_MAX_REG_WIDTH = 64;
    localparam int TUBE_MAX_RD_WIDTH  = 16;

    typedef struct packed {
        logic [TUBE_MAX_RD_WIDTH-1:0]  rd;
        logic [TUBE_MAX_REG_WIDTH-1:0] data;
    } tube_entry_t;

    // One extra pointer bit distinguishes a full buffer from an empty one.
    function automatic int tube_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tube_wb.sv
`default_nettype none
// ============================================================================
// Module      : tube_wb
// Description : In-order result tracking and writeback buffer for a
//               fixed-order pipelined execution tube. Optional busy
//               scoreboard output is enabled by TUBE_WB_SCOREBOARD_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tube_wb
    import tube_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int RD_WIDTH  = 5,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [RD_WIDTH-1:0]     issue_rd,
    output logic                    issue_ready,
    output logic                    tube_valid,
    input  logic                    res_valid,
    input  logic [REG_WIDTH-1:0]    res_data,
    output logic                    wb_valid,
    output logic [RD_WIDTH-1:0]     wb_rd,
    output logic [REG_WIDTH-1:0]    wb_data,
    input  logic                    wb_ready,
`ifdef TUBE_WB_SCOREBOARD_EN
    output logic [2**RD_WIDTH-1:0]  busy,
`endif
    output logic                    err
);

    localparam int                 c_ptr_w = tube_ptr_width(DEPTH);
    localparam int                 c_idx_w = c_ptr_w - 1;
    localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);

    logic [c_ptr_w-1:0] r_alloc;
    logic [c_ptr_w-1:0] r_fill;
    logic [c_ptr_w-1:0] r_retire;
    logic               r_err;
    tube_entry_t        r_mem [DEPTH];

    logic [c_ptr_w-1:0] w_occupancy;
    logic               w_issue_fire;
    logic               w_res_take;
    logic               w_res_spurious;
    logic               w_retire_fire;
    logic [c_idx_w-1:0] w_alloc_idx;
    logic [c_idx_w-1:0] w_fill_idx;
    logic [c_idx_w-1:0] w_retire_idx;

    assign w_alloc_idx  = r_alloc[c_idx_w-1:0];
    assign w_fill_idx   = r_fill[c_idx_w-1:0];
    assign w_retire_idx = r_retire[c_idx_w-1:0];

    // Occupancy counts every slot from allocation until retirement, so a
    // result can never arrive without a free slot already reserved for it.
    assign w_occupancy    = r_alloc - r_retire;
    assign issue_ready    = (w_occupancy != c_depth);
    assign tube_valid     = issue_valid & issue_ready;
    assign w_issue_fire   = tube_valid;
    assign w_res_take     = res_valid & (r_fill != r_alloc);
    assign w_res_spurious = res_valid & (r_fill == r_alloc);
    assign wb_valid       = (r_fill != r_retire);
    assign w_retire_fire  = wb_valid & wb_ready;

    assign wb_rd   = RD_WIDTH'(r_mem[w_retire_idx].rd);
    assign wb_data = REG_WIDTH'(r_mem[w_retire_idx].data);
    assign err     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc  <= '0;
            r_fill   <= '0;
            r_retire <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_issue_fire) begin
                r_alloc <= r_alloc + c_one;
            end
            if (w_res_take) begin
                r_fill <= r_fill + c_one;
            end
            if (w_retire_fire) begin
                r_retire <= r_retire + c_one;
            end
            if (w_res_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entry storage is not reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (w_issue_fire) begin
            r_mem[w_alloc_idx].rd <= TUBE_MAX_RD_WIDTH'(issue_rd);
        end
        if (w_res_take) begin
            r_mem[w_fill_idx].data <= TUBE_MAX_REG_WIDTH'(res_data);
        end
    end

`ifdef TUBE_WB_SCOREBOARD_EN
    // A slot is live when its distance past retire is below the occupancy.
    always_comb begin
        busy = '0;
        for (int j = 0; j < DEPTH; j++) begin
            logic [c_idx_w-1:0] w_off;
            w_off = c_idx_w'(j) - w_retire_idx;
            if ({1'b0, w_off} < w_occupancy) begin
                busy[RD_WIDTH'(r_mem[j].rd)] = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
